mfm_decoder: RTL



---
 rtl/mfm_decoder_if.sv | 22 ++
 rtl/mfm_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mfm_decoder_if.sv
// Cell-stream / decoded-byte bundle between read-channel cell recovery and the
// byte-level controller. The cell source is the master; the decoder is the slave.
interface mfm_decoder_if;
    logic       hunt;
    logic       cell_valid;
    logic       cell_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       mark;
    logic       code_err;
    logic       synced;

    modport master (
        output hunt, cell_valid, cell_in,
        input  data_out, data_valid, mark, code_err, synced
    );

    modport slave (
        input  hunt, cell_valid, cell_in,
        output data_out, data_valid, mark, code_err, synced
    );
endinterface

// File: rtl/mfm_decoder.sv
// MFM receive decoder: hunts for the 0x4489 sync mark, then frames every
// 16 cells into a data byte, checks the MFM clock rule and drops sync after
// ERR_LIMIT consecutive errored bytes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | sliding search for 0x4489 on every accepted cell
// ST_SYNCED | byte framing established, decode every 16th cell
module mfm_decoder #(
    parameter int ERR_LIMIT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mfm_decoder_if.slave  bus
);

    typedef enum logic {ST_HUNT, ST_SYNCED} state_t;

    localparam logic [15:0] SYNC_PAT = 16'h4489;
    localparam logic [7:0]  SYNC_BYTE = 8'hA1;
    localparam logic [3:0]  ERR_LIM  = 4'(ERR_LIMIT);

    state_t      state, state_n;
    logic [15:0] win, win_n;
    logic [3:0]  cell_cnt, cell_cnt_n;
    logic [3:0]  err_cnt, err_cnt_n;
    logic        prev_d, prev_d_n;
    logic [7:0]  data_q, data_n;
    logic        dv_q, dv_n;
    logic        mark_q, mark_n;
    logic        cerr_q, cerr_n;
    logic        synced_q, synced_n;

    logic [15:0] nextwin;
    logic [7:0]  dec_byte;
    logic        clk_viol;
    logic        d_prev;
    logic [3:0]  err_inc;

    assign nextwin = {win[14:0], bus.cell_in};
    assign err_inc = err_cnt + 4'd1;

    // Split the window into (clock, data) pairs and check each clock cell
    // against the one implied by its neighbouring data cells.
    always_comb begin
        dec_byte = '0;
        clk_viol = 1'b0;
        d_prev   = prev_d;
        for (int i = 0; i < 8; i++) begin
            dec_byte[7-i] = nextwin[14-2*i];
            if (nextwin[15-2*i] != (~d_prev & ~nextwin[14-2*i]))
                clk_viol = 1'b1;
            d_prev = nextwin[14-2*i];
        end
    end

    // Next-state and next-output logic; hunt overrides any cell in the same cycle.
    always_comb begin
        state_n    = state;
        win_n      = win;
        cell_cnt_n = cell_cnt;
        err_cnt_n  = err_cnt;
        prev_d_n   = prev_d;
        data_n     = data_q;
        dv_n       = 1'b0;
        mark_n     = mark_q;
        cerr_n     = cerr_q;

        if (bus.hunt) begin
            state_n    = ST_HUNT;
            win_n      = '0;
            cell_cnt_n = '0;
            err_cnt_n  = '0;
        end else if (bus.cell_valid) begin
            win_n = nextwin;
            case (state)
                ST_HUNT: begin
                    if (nextwin == SYNC_PAT) begin
                        state_n    = ST_SYNCED;
                        cell_cnt_n = '0;
                        err_cnt_n  = '0;
                        prev_d_n   = 1'b1;
                        data_n     = SYNC_BYTE;
                        mark_n     = 1'b1;
                        cerr_n     = 1'b0;
                        dv_n       = 1'b1;
                    end
                end
                ST_SYNCED: begin
                    if (cell_cnt == 4'd15) begin
                        cell_cnt_n = '0;
                        dv_n       = 1'b1;
                        data_n     = dec_byte;
                        prev_d_n   = dec_byte[0];
                        if (nextwin == SYNC_PAT) begin
                            // The missing clock in the mark is intentional, so no rule check.
                            mark_n    = 1'b1;
                            cerr_n    = 1'b0;
                            err_cnt_n = '0;
                        end else if (clk_viol) begin
                            mark_n = 1'b0;
                            cerr_n = 1'b1;
                            if (err_inc == ERR_LIM) begin
                                state_n   = ST_HUNT;
                                win_n     = '0;
                                err_cnt_n = '0;
                            end else begin
                                err_cnt_n = err_inc;
                            end
                        end else begin
                            mark_n    = 1'b0;
                            cerr_n    = 1'b0;
                            err_cnt_n = '0;
                        end
                    end else begin
                        cell_cnt_n = cell_cnt + 4'd1;
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
        synced_n = (state_n == ST_SYNCED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_HUNT;
            win      <= '0;
            cell_cnt <= '0;
            err_cnt  <= '0;
            prev_d   <= 1'b0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            mark_q   <= 1'b0;
            cerr_q   <= 1'b0;
            synced_q <= 1'b0;
        end else begin
            state    <= state_n;
            win      <= win_n;
            cell_cnt <= cell_cnt_n;
            err_cnt  <= err_cnt_n;
            prev_d   <= prev_d_n;
            data_q   <= data_n;
            dv_q     <= dv_n;
            mark_q   <= mark_n;
            cerr_q   <= cerr_n;
            synced_q <= synced_n;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = dv_q;
    assign bus.mark       = mark_q;
    assign bus.code_err   = cerr_q;
    assign bus.synced     = synced_q;

endmodule
